cic_comp_fir: RTL and testbench

Decimate-by-2 compensation FIR consuming the strobed output of the CIC decimator. It corrects CIC passband droop and halves the sample rate. Single serial multiply-accumulate engine: one tap per clock over a circular sample buffer. Output is a registered sample with a one-cycle `cke_out` strobe, feeding the next DSP stage.

---
 rtl/cic_comp_fir.sv | 100 ++++++++++
 tb/tb_cic_comp_fir.sv | 166 ++++++++++++++++
 2 files changed

// File: rtl/cic_comp_fir.sv
// Decimate-by-2 CIC droop-compensation FIR: one serial MAC over a circular sample buffer.
// Define CIC_COMP_SAT_EN to saturate the rounded output instead of wrapping it.
module cic_comp_fir #(
   parameter int taps       = 16,
   parameter int width      = 16,
   parameter int coef_width = 16,
   parameter logic [taps*coef_width-1:0] coef = '0
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             cke,
   input  logic [width-1:0] din,
   output logic [width-1:0] dout,
   output logic             cke_out,
   output logic             busy,
   output logic             ovf
);
   localparam int aw   = (taps > 1) ? $clog2(taps) : 1;
   localparam int accw = width + coef_width + $clog2(taps);
   localparam logic signed [accw-1:0] half = accw'(1) << (coef_width - 2);

   typedef enum logic [1:0] {IDLE, MAC, OUT} state_t;
   state_t state;

   logic signed [width-1:0]            sbuf [taps];
   logic [aw-1:0]                      wp, k, rd_idx;
   logic [aw:0]                        idx_sum;
   logic                               ph;
   logic signed [accw-1:0]             acc, acc_nxt, rnd;
   logic signed [coef_width-1:0]       coef_k;
   logic signed [width+coef_width-1:0] prod;
   logic [width-1:0]                   res;

   // Tap k reads the k-th newest sample: buf[(wp-1-k) mod taps]
   always_comb begin
      idx_sum = {1'b0, wp} + (aw+1)'(taps - 1) - {1'b0, k};
      rd_idx  = (idx_sum >= (aw+1)'(taps)) ? aw'(idx_sum - (aw+1)'(taps)) : aw'(idx_sum);
      coef_k  = coef[k*coef_width +: coef_width];
      prod    = sbuf[rd_idx] * coef_k;
      acc_nxt = acc + accw'(prod);
      rnd     = (acc_nxt + half) >>> (coef_width - 1);
   end

`ifdef CIC_COMP_SAT_EN
   localparam logic signed [accw-1:0] smax = {{(accw-width+1){1'b0}}, {(width-1){1'b1}}};
   localparam logic signed [accw-1:0] smin = ~smax;
   always_comb begin
      if (rnd > smax)      res = smax[width-1:0];
      else if (rnd < smin) res = smin[width-1:0];
      else                 res = rnd[width-1:0];
   end
`else
   logic unused_rnd_hi;
   assign unused_rnd_hi = ^rnd[accw-1:width];
   assign res = rnd[width-1:0];
`endif

   assign busy = (state != IDLE);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state   <= IDLE;
         wp      <= '0;
         k       <= '0;
         ph      <= 1'b0;
         acc     <= '0;
         dout    <= '0;
         cke_out <= 1'b0;
         ovf     <= 1'b0;
         for (int i = 0; i < taps; i++) sbuf[i] <= '0;
      end else begin
         cke_out <= 1'b0;
         if (cke && state != IDLE) ovf <= 1'b1;
         case (state)
            IDLE: if (cke) begin
               sbuf[wp] <= din;
               wp       <= (wp == aw'(taps - 1)) ? '0 : wp + 1'b1;
               ph       <= ~ph;
               if (ph) begin
                  state <= MAC;
                  acc   <= '0;
                  k     <= '0;
               end
            end
            // Result is registered on the last tap so cke_out shows in the OUT cycle
            MAC: begin
               acc <= acc_nxt;
               k   <= k + 1'b1;
               if (k == aw'(taps - 1)) begin
                  state   <= OUT;
                  dout    <= res;
                  cke_out <= 1'b1;
               end
            end
            OUT:     state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_cic_comp_fir.sv
// Randomized and directed checks of cic_comp_fir (taps=4) against a sample-history reference model.
module tb_cic_comp_fir;
   localparam int TAPS = 4;
   localparam int W    = 16;
   localparam int CW   = 16;
   localparam logic [TAPS*CW-1:0] COEF_A = {16'sd32767, -16'sd16384, 16'sd16384, 16'sd8192};
   localparam logic [TAPS*CW-1:0] COEF_B = {4{16'sd16384}};

   logic clk = 0, rst_n = 0, cke = 0;
   logic [W-1:0] din = '0;
   logic [W-1:0] dout_a, dout_b;
   logic cke_out_a, cke_out_b, busy_a, busy_b, ovf_a, ovf_b;

   always #5 clk = ~clk;

   cic_comp_fir #(.taps(TAPS), .width(W), .coef_width(CW), .coef(COEF_A)) u_a (
      .clk(clk), .rst_n(rst_n), .cke(cke), .din(din),
      .dout(dout_a), .cke_out(cke_out_a), .busy(busy_a), .ovf(ovf_a));
   cic_comp_fir #(.taps(TAPS), .width(W), .coef_width(CW), .coef(COEF_B)) u_b (
      .clk(clk), .rst_n(rst_n), .cke(cke), .din(din),
      .dout(dout_b), .cke_out(cke_out_b), .busy(busy_b), .ovf(ovf_b));

   int n_chk = 0, n_pass = 0;
   task automatic chk(input string tag, input longint obs, input longint exp);
      n_chk++;
      if (obs == exp) n_pass++;
      else $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
   endtask

   // reference model: list of accepted samples plus a countdown of busy cycles
   int     ca [TAPS] = '{8192, 16384, -16384, 32767};
   int     cb [TAPS] = '{16384, 16384, 16384, 16384};
   int     hist [$];
   int     busy_cnt;
   bit     m_ph, m_cke_out, m_ovf;
   longint m_dout_a, m_dout_b, pend_a, pend_b;

   function automatic longint filt(input int cf [TAPS]);
      longint acc = 0, r;
      logic signed [W-1:0] t;
      int n = hist.size();
      for (int j = 0; j < TAPS; j++)
         if (n - 1 - j >= 0) acc += longint'(hist[n-1-j]) * longint'(cf[j]);
      r = (acc + (64'sd1 <<< (CW - 2))) >>> (CW - 1);
`ifdef CIC_COMP_SAT_EN
      if (r > 32767) r = 32767;
      if (r < -32768) r = -32768;
`else
      t = r[W-1:0];
      r = longint'(t);
`endif
      return r;
   endfunction

   task automatic model_reset();
      hist.delete();
      busy_cnt = 0; m_ph = 0; m_cke_out = 0; m_ovf = 0;
      m_dout_a = 0; m_dout_b = 0; pend_a = 0; pend_b = 0;
   endtask

   task automatic model_edge(input bit c, input logic [W-1:0] d);
      m_cke_out = 0;
      if (busy_cnt > 0) begin
         if (c) m_ovf = 1;
         busy_cnt--;
         if (busy_cnt == 1) begin
            m_cke_out = 1; m_dout_a = pend_a; m_dout_b = pend_b;
         end
      end else if (c) begin
         hist.push_back(int'($signed(d)));
         if (hist.size() > TAPS) void'(hist.pop_front());
         if (m_ph) begin
            busy_cnt = TAPS + 1;
            pend_a = filt(ca);
            pend_b = filt(cb);
         end
         m_ph = ~m_ph;
      end
   endtask

   task automatic check_all(input string ph);
      chk({ph, ".cke_out_a"}, longint'(cke_out_a), longint'(m_cke_out));
      chk({ph, ".dout_a"}, longint'($signed(dout_a)), m_dout_a);
      chk({ph, ".busy"}, longint'(busy_a), longint'(busy_cnt > 0));
      chk({ph, ".ovf"}, longint'(ovf_a), longint'(m_ovf));
      chk({ph, ".cke_out_b"}, longint'(cke_out_b), longint'(m_cke_out));
      chk({ph, ".dout_b"}, longint'($signed(dout_b)), m_dout_b);
   endtask

   // called at a negedge: drive, take one rising edge, check at the following negedge
   task automatic step(input string ph, input bit c, input logic [W-1:0] d);
      cke = c; din = d;
      @(posedge clk);
      model_edge(c, d);
      @(negedge clk);
      check_all(ph);
   endtask

   task automatic strobe(input string ph, input logic [W-1:0] d, input int gap);
      step(ph, 1'b1, d);
      repeat (gap - 1) step(ph, 1'b0, '0);
   endtask

   initial begin
      model_reset();
      repeat (2) @(negedge clk);
      check_all("reset");
      rst_n = 1;

      strobe("impulse", 16'sd1000, 8);
      repeat (7) strobe("impulse", '0, 8);

      repeat (6) strobe("dc", 16'sd1000, 8);

      repeat (6) strobe("sat", 16'sd32767, 7);
`ifdef CIC_COMP_SAT_EN
      chk("sat.steady", longint'($signed(dout_b)), 32767);
`else
      chk("sat.steady", longint'($signed(dout_b)), -2);
`endif

      strobe("ovr", 16'sd300, 8);
      step("ovr", 1'b1, 16'sd700);
      step("ovr", 1'b0, '0);
      step("ovr", 1'b1, 16'sd5000);
      repeat (8) step("ovr", 1'b0, '0);
      repeat (4) strobe("ovr", 16'($urandom), 8);
      chk("ovr.sticky", longint'(ovf_a), 1);

      // abort a computation with an asynchronous reset
      step("rst", 1'b1, 16'sd1234);
      step("rst", 1'b1, 16'sd4321);
      step("rst", 1'b0, '0);
      #2 rst_n = 0;
      #1;
      model_reset();
      chk("rst.dout", longint'(dout_a), 0);
      chk("rst.cke_out", longint'(cke_out_a), 0);
      chk("rst.busy", longint'(busy_a), 0);
      chk("rst.ovf", longint'(ovf_a), 0);
      @(negedge clk);
      rst_n = 1;
      repeat (8) step("rst", 1'b0, '0);

      // tightest legal spacing: next cke lands in the cycle after cke_out
      repeat (3 * TAPS / 2) begin
         step("b2b", 1'b1, 16'($urandom));
         step("b2b", 1'b1, 16'($urandom));
         repeat (TAPS + 1) step("b2b", 1'b0, '0);
      end
      chk("b2b.ovf", longint'(ovf_a), 0);

      for (int i = 0; i < 400; i++)
         step("rand", ($urandom_range(0, 2) == 0), 16'($urandom));
      repeat (8) step("rand", 1'b0, '0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL timeout: got running expected finished");
      $fatal(1);
   end
endmodule
